// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, one-cycle synchronous-read instruction RAM and IF/ID register.
// Define IF_PERF_CNT_EN to build the fetch/bubble performance counters (ports read 0 otherwise).

package if_stage_pkg;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;
endpackage

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    input  logic        imem_we,
    input  logic [12:0] imem_waddr,
    input  logic [31:0] imem_wdata,
    output if_id_t      out,
    output logic [31:0] pc_f,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
);

    logic [31:0] mem [0:8191];
    logic [31:0] douta;
    logic        mem_ok;
    logic        hold;
    logic [31:0] pc_next;
    logic [12:0] ram_addr;
    logic [1:0]  unused_tgt_bits;

    assign unused_tgt_bits = pc_target_e[1:0];

    // The RAM output only matches pc_f if the previous edge read pc_f rather than wrote.
    assign hold = stall_f | ~mem_ok;

    // NOTE: assign the default first so every path drives pc_next and no latch is inferred.
    always_comb begin
        pc_next = pc_f + 32'd4;
        if (pc_src_e)
            pc_next = {pc_target_e[31:2], 2'b00};
        else if (hold)
            pc_next = pc_f;
    end

    assign ram_addr = imem_we ? imem_waddr : pc_next[14:2];

    // NOTE: the RAM array and its output register have no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (imem_we)
            mem[ram_addr] <= imem_wdata;
        douta <= mem[ram_addr];
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f         <= RESET_PC;
            mem_ok       <= 1'b0;
            out.instr    <= NOP_INSTR;
            out.pc       <= RESET_PC;
            out.pc_plus4 <= RESET_PC + 32'd4;
            out.valid    <= 1'b0;
        end else begin
            pc_f   <= pc_next;
            mem_ok <= ~imem_we;
            if (flush_d) begin
                out.instr <= NOP_INSTR;
                out.valid <= 1'b0;
            end else if (!stall_f) begin
                if (!mem_ok) begin
                    out.instr <= NOP_INSTR;
                    out.valid <= 1'b0;
                end else begin
                    out.instr    <= douta;
                    out.pc       <= pc_f;
                    out.pc_plus4 <= pc_f + 32'd4;
                    out.valid    <= 1'b1;
                end
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic fetch_ev;
    logic bubble_ev;

    assign fetch_ev  = ~flush_d & ~stall_f &  mem_ok;
    assign bubble_ev = ~flush_d & ~stall_f & ~mem_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (fetch_ev)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (bubble_ev)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`else
    assign fetch_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a behavioural fetch model queues the expected state per edge and a
// monitor compares after each rising edge; directed scenarios add fixed-value checks.

module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        if_id_t      out;
        logic [31:0] pc_f;
        logic [31:0] fcnt;
        logic [31:0] bcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_f = 1'b0;
    logic        flush_d = 1'b0;
    logic        pc_src_e = 1'b0;
    logic [31:0] pc_target_e = '0;
    logic        imem_we = 1'b0;
    logic [12:0] imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    if_id_t      out;
    logic [31:0] pc_f;
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .flush_d(flush_d),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .out(out), .pc_f(pc_f),
        .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model: program image, fetch address, whether the RAM holds the word at that address.
    logic [31:0] ref_mem [8192];
    logic [31:0] m_pc;
    bit          m_fresh;
    if_id_t      m_out;
    logic [31:0] m_fcnt;
    logic [31:0] m_bcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_fresh = 1'b0;
        m_out   = '{instr: NOP, pc: 32'h0, pc_plus4: 32'h4, valid: 1'b0};
        m_fcnt  = 0;
        m_bcnt  = 0;
    endtask

    task automatic model_step(input bit st, input bit fl, input bit src, input logic [31:0] tgt,
                              input bit we, input logic [12:0] wa, input logic [31:0] wd, input bit rn);
        exp_t        e;
        logic [31:0] word;
        logic [31:0] npc;
        if (!rn) begin
            model_reset();
        end else begin
            // The word presented this cycle is the program image at the fetch PC, before this edge's write.
            word = ref_mem[m_pc[14:2]];
            if (src)                 npc = tgt & 32'hFFFF_FFFC;
            else if (st || !m_fresh) npc = m_pc;
            else                     npc = m_pc + 4;
            if (fl) begin
                m_out.instr = NOP;
                m_out.valid = 1'b0;
            end else if (st) begin
                m_out = m_out;
            end else if (!m_fresh) begin
                m_out.instr = NOP;
                m_out.valid = 1'b0;
                m_bcnt++;
            end else begin
                m_out = '{instr: word, pc: m_pc, pc_plus4: m_pc + 4, valid: 1'b1};
                m_fcnt++;
            end
            if (we) ref_mem[wa] = wd;
            m_pc    = npc;
            m_fresh = !we;
        end
        e.out  = m_out;
        e.pc_f = m_pc;
        e.fcnt = PERF ? m_fcnt : 32'h0;
        e.bcnt = PERF ? m_bcnt : 32'h0;
        exp_q.push_back(e);
    endtask

    // Called at a falling edge: drive one cycle of inputs, queue the expectation, move to the next falling edge.
    task automatic cyc(input bit st = 1'b0, input bit fl = 1'b0, input bit src = 1'b0,
                       input logic [31:0] tgt = 32'h0, input bit we = 1'b0,
                       input logic [12:0] wa = 13'h0, input logic [31:0] wd = 32'h0,
                       input bit rn = 1'b1);
        rst_n       = rn;
        stall_f     = st;
        flush_d     = fl;
        pc_src_e    = src;
        pc_target_e = tgt;
        imem_we     = we;
        imem_waddr  = wa;
        imem_wdata  = wd;
        model_step(st, fl, src, tgt, we, wa, wd, rn);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_instr",    out.instr,    e.out.instr);
                check("sb_pc",       out.pc,       e.out.pc);
                check("sb_pc_plus4", out.pc_plus4, e.out.pc_plus4);
                check("sb_valid",    {31'b0, out.valid}, {31'b0, e.out.valid});
                check("sb_pc_f",     pc_f,         e.pc_f);
                check("sb_fetch_cnt",  fetch_cnt,  e.fcnt);
                check("sb_bubble_cnt", bubble_cnt, e.bcnt);
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        foreach (ref_mem[i]) ref_mem[i] = 32'h0;
        model_reset();
        @(negedge clk);

        repeat (3) cyc(.rn(1'b0));
        check("reset_valid", {31'b0, out.valid}, 32'h0);
        check("reset_instr", out.instr, NOP);
        check("reset_pc_plus4", out.pc_plus4, 32'h4);

        for (int i = 0; i < 512; i++) cyc(.we(1'b1), .wa(13'(i)), .wd($urandom()));
        cyc(.we(1'b1), .wa(13'h1FFF), .wd($urandom()));

        // Reset release and counters.
        repeat (3) cyc(.rn(1'b0));
        cyc();
        check("rel_e1_valid", {31'b0, out.valid}, 32'h0);
        check("rel_e1_pc_f", pc_f, 32'h0);
        cyc();
        check("rel_e2_pc", out.pc, 32'h0);
        check("rel_e2_instr", out.instr, ref_mem[0]);
        check("rel_e2_valid", {31'b0, out.valid}, 32'h1);
        cyc();
        check("rel_e3_pc", out.pc, 32'h4);
        repeat (7) cyc();
        cyc(.we(1'b1), .wa(13'd300), .wd($urandom()));
        cyc();
        check("cnt_fetch", fetch_cnt, PERF ? 32'd10 : 32'd0);
        check("cnt_bubble", bubble_cnt, PERF ? 32'd2 : 32'd0);

        // Program load colliding with a redirect straight out of reset.
        repeat (3) cyc(.rn(1'b0));
        cyc(.we(1'b1), .wa(13'd5), .wd(32'h0050_0093), .src(1'b1), .tgt(32'h14));
        check("load_b1_valid", {31'b0, out.valid}, 32'h0);
        cyc();
        check("load_b2_valid", {31'b0, out.valid}, 32'h0);
        check("load_pc_f", pc_f, 32'h14);
        cyc();
        check("load_pc", out.pc, 32'h14);
        check("load_instr", out.instr, 32'h0050_0093);
        check("load_valid", {31'b0, out.valid}, 32'h1);

        // Redirect without and with a flush of the redirect-cycle slot.
        cyc(.src(1'b1), .tgt(32'h20));
        cyc(.src(1'b1), .tgt(32'h103));
        check("redir_pc_f", pc_f, 32'h100);
        check("redir_slot_pc", out.pc, 32'h20);
        check("redir_slot_valid", {31'b0, out.valid}, 32'h1);
        cyc();
        check("redir_out_pc", out.pc, 32'h100);
        cyc(.src(1'b1), .tgt(32'h20));
        cyc(.src(1'b1), .tgt(32'h103), .fl(1'b1));
        check("flush_valid", {31'b0, out.valid}, 32'h0);
        check("flush_instr", out.instr, NOP);
        cyc();
        check("flush_next_pc", out.pc, 32'h100);

        // Stall for three cycles at 0x40.
        cyc(.src(1'b1), .tgt(32'h40));
        repeat (3) begin
            cyc(.st(1'b1));
            check("stall_pc_f", pc_f, 32'h40);
        end
        cyc();
        check("stall_rel_pc", out.pc, 32'h40);
        cyc();
        check("stall_rel_next", out.pc, 32'h44);

        // Stall, flush and redirect together.
        cyc(.st(1'b1), .fl(1'b1), .src(1'b1), .tgt(32'h80));
        check("combo_valid", {31'b0, out.valid}, 32'h0);
        check("combo_pc_f", pc_f, 32'h80);
        cyc();
        check("combo_next_pc", out.pc, 32'h80);
        check("combo_next_valid", {31'b0, out.valid}, 32'h1);

        // Word address wraps while upper PC bits are kept.
        cyc(.src(1'b1), .tgt(32'h1234_7FFC));
        cyc();
        check("wrap_pc", out.pc, 32'h1234_7FFC);
        check("wrap_instr", out.instr, ref_mem[8191]);
        cyc();
        check("wrap_next_pc", out.pc, 32'h1234_8000);
        check("wrap_next_instr", out.instr, ref_mem[0]);

        // Random traffic; fetches stay inside the loaded words 0..511 and 8191.
        for (int n = 0; n < 3000; n++) begin
            bit          st, fl, src, we;
            logic [31:0] tgt, r;
            int          idx;
            if ($urandom_range(0, 199) == 0) begin
                cyc(.rn(1'b0));
            end else begin
                st  = ($urandom_range(0, 99) < 20);
                fl  = ($urandom_range(0, 99) < 10);
                we  = ($urandom_range(0, 99) < 5);
                src = ($urandom_range(0, 99) < 10) ||
                      (m_pc[14:2] >= 13'd470 && m_pc[14:2] != 13'h1FFF);
                idx = ($urandom_range(0, 19) == 0) ? 8191 : int'($urandom_range(0, 469));
                r   = $urandom();
                tgt = (r & 32'hFFFF_8003) | (32'(idx) << 2);
                cyc(.st(st), .fl(fl), .src(src), .tgt(tgt), .we(we),
                    .wa(13'($urandom_range(0, 511))), .wd($urandom()));
            end
        end
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
